vx_ibuffer_sched: RTL and testbench
===================================

VX_IBUFFER_SCHED -- requirements
Module: VX_ibuffer_sched

Parameters
REQ-001 NUM_WARPS, default 4, number of per-warp instruction buffer lanes arbitrated; legal range 1..32.
REQ-002 DATAW, default 128, width of the packed decoded-instruction payload per lane (uuid, tmask, PC, ex_type, op_type, op_mod, wb, use_PC, use_imm, imm, rd, rs1..rs3).

Interface
REQ-003 The clock port SHALL be: clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 The reset port SHALL be: reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  NUM_WARPS  per-warp instruction available.
REQ-006 in_data  in  NUM_WARPS*DATAW  per-warp payload; lane i occupies bits [i*DATAW +: DATAW].
REQ-007 in_ready  out  NUM_WARPS  per-warp dequeue acknowledge.
REQ-008 stall_mask  in  NUM_WARPS  per-warp scoreboard/barrier hold; 1 = lane ineligible.
REQ-009 out_valid  out  1  issue slot holds an instruction.
REQ-010 out_wid  out  max(1,clog2(NUM_WARPS))  warp id of held instruction.
REQ-011 out_data  out  DATAW  held payload.
REQ-012 out_ready  in  1  downstream accepts.
REQ-013 perf_issued  out  32  count of instructions accepted downstream.
REQ-014 perf_stalls  out  32  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 eligible[i] SHALL equal in_valid[i] AND NOT stall_mask[i].
REQ-016 load_en SHALL equal (NOT out_valid) OR out_ready.
REQ-017 When load_en=1 and any lane is eligible, the block SHALL grant the first eligible lane at or after rr_ptr in ascending index, wrapping modulo NUM_WARPS.
REQ-018 in_ready SHALL be one-hot or zero, combinationally equal to grant AND load_en; no lane is acknowledged when no lane is eligible.
REQ-019 On a grant, out_valid, out_wid, and out_data SHALL register the granted lane's values on the next edge; latency is 1 cycle from in_valid to out_valid.
REQ-020 On a grant, rr_ptr SHALL become (granted index + 1) mod NUM_WARPS; rr_ptr SHALL be unchanged without a grant.
REQ-021 When load_en=1 and no lane is eligible, out_valid SHALL become 0 on the next edge.
REQ-022 When out_valid=1 and out_ready=0, out_valid, out_wid, and out_data SHALL hold stable, and all in_ready bits SHALL be 0.
REQ-023 Back-to-back operation SHALL be supported: with out_ready held at 1, one instruction issues per cycle.
REQ-024 Changes to stall_mask SHALL affect only future grants; an instruction already held is never revoked.
REQ-025 perf_issued SHALL increment on out_valid AND out_ready, and perf_stalls on out_valid AND NOT out_ready; both wrap from 2^32-1 to 0.
REQ-026 With NUM_WARPS=1, the block SHALL always grant lane 0 and drive out_wid to 0.

Reset
REQ-027 While reset=1, the block SHALL drive out_valid=0, out_wid=0, out_data=0, rr_ptr=0, perf_issued=0, perf_stalls=0, and in_ready=0.
REQ-028 A reset asserted while an instruction is held SHALL discard that instruction, with no in_ready pulse in that cycle.
REQ-029 The first grant after reset release SHALL search from lane 0.

Verification
REQ-030 Fairness: NUM_WARPS=4, in_valid=4'b1111, stall_mask=0, out_ready=1 -> out_wid sequence 0,1,2,3,0,... with exactly one in_ready bit set per cycle.
REQ-031 Skip and wrap: rr_ptr=3, eligible=4'b0101 -> grant lane 0 (in_ready=4'b0001), then rr_ptr=1.
REQ-032 Backpressure: out_valid=1 with wid 2 and out_ready=0 for 5 cycles -> out_data stable, in_ready=0, perf_stalls increments by 5; the next out_ready=1 cycle reloads in the same cycle.
REQ-033 Stall mask: in_valid=4'b0011, stall_mask=4'b0001 -> only lane 1 is granted; clearing stall_mask then grants lane 0 the next cycle.
REQ-034 Reset mid-flight: reset asserted with out_valid=1 -> the next cycle shows out_valid=0, perf counters 0, and the first post-reset grant comes from the lowest eligible lane.
REQ-035 Counter wrap: perf_issued preloaded to 0xFFFFFFFF via a forced state, then one accepted issue -> perf_issued=0.

Source files
------------

// File: rtl/vx_ibuffer_sched_if.sv
// Issue-side bundle between the per-warp instruction buffers and the scheduler.
// The scheduler takes the slave side; the buffers and downstream take master.
interface vx_ibuffer_sched_if #(
    parameter int NUM_WARPS = 4,
    parameter int DATAW     = 128,
    parameter int WIDW      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
);
    logic [NUM_WARPS-1:0]       in_valid;
    logic [NUM_WARPS*DATAW-1:0] in_data;
    logic [NUM_WARPS-1:0]       in_ready;
    logic [NUM_WARPS-1:0]       stall_mask;
    logic                       out_valid;
    logic [WIDW-1:0]            out_wid;
    logic [DATAW-1:0]           out_data;
    logic                       out_ready;
    logic [31:0]                perf_issued;
    logic [31:0]                perf_stalls;

    modport master (
        output in_valid, in_data, stall_mask, out_ready,
        input  in_ready, out_valid, out_wid, out_data,
        input  perf_issued, perf_stalls
    );

    modport slave (
        input  in_valid, in_data, stall_mask, out_ready,
        output in_ready, out_valid, out_wid, out_data,
        output perf_issued, perf_stalls
    );
endinterface

// File: rtl/vx_ibuffer_sched.sv
// Round-robin issue scheduler: picks one eligible warp lane into a single
// registered issue slot, with backpressure and issue/stall counters.
module vx_ibuffer_sched #(
    parameter int NUM_WARPS = 4,
    parameter int DATAW     = 128,
    parameter int WIDW      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input logic clk,
    input logic reset,
    vx_ibuffer_sched_if.slave bus
);
    logic [NUM_WARPS-1:0] eligible;
    logic                 load_en;
    logic                 found;
    logic [WIDW-1:0]      gidx;
    logic [WIDW-1:0]      rr_ptr;
    logic [WIDW-1:0]      rr_next;
    logic                 valid_q;
    logic [WIDW-1:0]      wid_q;
    logic [DATAW-1:0]     data_q;
    logic [31:0]          issued_q;
    logic [31:0]          stalls_q;

    assign eligible = bus.in_valid & ~bus.stall_mask;
    assign load_en  = ~valid_q | bus.out_ready;

    // First eligible lane at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int k = 0; k < NUM_WARPS; k++) begin
            int j;
            j = (int'(rr_ptr) + k) % NUM_WARPS;
            if (!found && eligible[j]) begin
                found = 1'b1;
                gidx  = WIDW'(j);
            end
        end
    end

    assign rr_next = (gidx == WIDW'(NUM_WARPS - 1)) ? '0 : gidx + 1'b1;

    always_comb begin
        bus.in_ready = '0;
        if (found && load_en && !reset)
            bus.in_ready = NUM_WARPS'(1) << gidx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            wid_q    <= '0;
            data_q   <= '0;
            rr_ptr   <= '0;
            issued_q <= '0;
            stalls_q <= '0;
        end else begin
            if (load_en) begin
                valid_q <= found;
                if (found) begin
                    wid_q  <= gidx;
                    data_q <= bus.in_data[gidx*DATAW +: DATAW];
                    rr_ptr <= rr_next;
                end
            end
            if (valid_q && bus.out_ready)
                issued_q <= issued_q + 32'd1;
            if (valid_q && !bus.out_ready)
                stalls_q <= stalls_q + 32'd1;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_wid     = wid_q;
    assign bus.out_data    = data_q;
    assign bus.perf_issued = issued_q;
    assign bus.perf_stalls = stalls_q;
endmodule

// File: tb/tb_vx_ibuffer_sched.sv
// Randomized and directed bench for vx_ibuffer_sched against a
// queue-free behavioural model of the round-robin issue slot.
module tb_vx_ibuffer_sched;
    localparam int N = 4;
    localparam int DW = 128;
    localparam int WW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_ibuffer_sched_if #(.NUM_WARPS(N), .DATAW(DW)) bus ();

    vx_ibuffer_sched #(.NUM_WARPS(N), .DATAW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model state: what the issue slot must hold right now.
    bit          m_valid;
    int          m_wid;
    bit [DW-1:0] m_data;
    int          m_ptr;
    bit [31:0]   m_issued;
    bit [31:0]   m_stalls;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic bit [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: drive inputs, check at negedge, advance the model.
    task automatic step(input bit [N-1:0] iv, input bit [N-1:0] sm,
                        input bit ordy, input bit rst);
        bit [N-1:0] exp_rdy;
        bit         load;
        bit         hit;
        int         g;
        @(posedge clk);
        #1;
        reset          = rst;
        bus.in_valid   = iv;
        bus.stall_mask = sm;
        bus.out_ready  = ordy;
        for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = rnd_data();
        @(negedge clk);
        load = !m_valid || ordy;
        hit  = 1'b0;
        g    = 0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (!hit && iv[j] && !sm[j]) begin
                hit = 1'b1;
                g   = j;
            end
        end
        exp_rdy = (!rst && load && hit) ? (N'(1) << g) : '0;
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("out_valid", bus.out_valid, m_valid);
        if (m_valid) begin
            chk("out_wid", bus.out_wid, m_wid);
            chk("out_data", bus.out_data, m_data);
        end
        chk("perf_issued", bus.perf_issued, m_issued);
        chk("perf_stalls", bus.perf_stalls, m_stalls);
        if (rst) begin
            m_valid  = 0;
            m_wid    = 0;
            m_data   = '0;
            m_ptr    = 0;
            m_issued = 0;
            m_stalls = 0;
        end else begin
            if (m_valid && ordy)  m_issued++;
            if (m_valid && !ordy) m_stalls++;
            if (load) begin
                m_valid = hit;
                if (hit) begin
                    m_wid  = g;
                    m_data = bus.in_data[g*DW +: DW];
                    m_ptr  = (g + 1) % N;
                end
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.in_valid   = '0;
        bus.in_data    = '0;
        bus.stall_mask = '0;
        bus.out_ready  = 1'b0;
        m_valid = 0; m_wid = 0; m_data = '0; m_ptr = 0;
        m_issued = 0; m_stalls = 0;
        step(4'b1111, 4'b0000, 1'b1, 1'b1);
        chk("rst_in_ready", bus.in_ready, 4'b0000);
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 128'd0);

        // Fairness: all lanes ready, downstream always accepting.
        step(4'b1111, 4'b0000, 1'b1, 1'b0);
        chk("fair_rdy0", bus.in_ready, 4'b0001);
        step(4'b1111, 4'b0000, 1'b1, 1'b0);
        chk("fair_rdy1", bus.in_ready, 4'b0010);
        chk("fair_wid0", bus.out_wid, 2'd0);
        step(4'b1111, 4'b0000, 1'b1, 1'b0);
        chk("fair_rdy2", bus.in_ready, 4'b0100);
        chk("fair_wid1", bus.out_wid, 2'd1);
        step(4'b1111, 4'b0000, 1'b1, 1'b0);
        chk("fair_rdy3", bus.in_ready, 4'b1000);
        chk("fair_wid2", bus.out_wid, 2'd2);
        step(4'b1111, 4'b0000, 1'b1, 1'b0);
        chk("fair_wrap", bus.in_ready, 4'b0001);
        chk("fair_wid3", bus.out_wid, 2'd3);

        // Skip and wrap from rr_ptr=3.
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b0100, 4'b0000, 1'b1, 1'b0);
        chk("skip_l2", bus.in_ready, 4'b0100);
        step(4'b0101, 4'b0000, 1'b1, 1'b0);
        chk("skip_wrap", bus.in_ready, 4'b0001);
        step(4'b0101, 4'b0000, 1'b1, 1'b0);
        chk("skip_ptr1", bus.in_ready, 4'b0100);

        // Backpressure with wid 2 held for five cycles.
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 4'b0000, 1'b0, 1'b0);
            chk("bp_rdy", bus.in_ready, 4'b0000);
            chk("bp_wid", bus.out_wid, 2'd2);
        end
        step(4'b1111, 4'b0000, 1'b1, 1'b0);
        chk("bp_stalls", bus.perf_stalls, 32'd5);
        chk("bp_reload", bus.in_ready, 4'b1000);

        // Stall mask holds lane 0 until cleared.
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b0011, 4'b0001, 1'b1, 1'b0);
        chk("sm_lane1", bus.in_ready, 4'b0010);
        step(4'b0011, 4'b0000, 1'b1, 1'b0);
        chk("sm_lane0", bus.in_ready, 4'b0001);

        // Reset while an instruction is held.
        step(4'b1111, 4'b0000, 1'b0, 1'b0);
        step(4'b1111, 4'b0000, 1'b0, 1'b1);
        chk("mid_rst_rdy", bus.in_ready, 4'b0000);
        step(4'b0110, 4'b0000, 1'b1, 1'b0);
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_perf", bus.perf_stalls, 32'd0);
        chk("mid_rst_grant", bus.in_ready, 4'b0010);

        // Issue counter wrap from a forced all-ones value.
        force dut.issued_q = 32'hFFFF_FFFF;
        m_issued = 32'hFFFF_FFFF;
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        release dut.issued_q;
        chk("wrap_pre", bus.perf_issued, 32'hFFFF_FFFF);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("wrap_post", bus.perf_issued, 32'd0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            step(N'($urandom), N'($urandom & $urandom),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
